fwd_ctrl: RTL
=============

Name: fwd_ctrl

Overview:
- Forwarding and hazard controller for the execute stage of the pipelined core.
- Tracks destination-register information for instructions in EX, MEM and WB.
- Drives the 2-bit select inputs of the two operand-forwarding 3:1 muxes (operand A, operand B) in front of the ALU.
- Raises a load-use stall request to the fetch/decode control.

Parameters:
- REG_ADDR_W, 5, width of a register-file address.
- ZERO_REG, 0, register address that is never forwarded; writes to it are ignored.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- arst_n  input  1  reset, synchronous, active-low.
- id_valid  input  1  decode stage holds a real instruction.
- id_rs1  input  REG_ADDR_W  source register 1 of the decoding instruction.
- id_rs2  input  REG_ADDR_W  source register 2 of the decoding instruction.
- id_rd  input  REG_ADDR_W  destination of the decoding instruction.
- id_reg_write  input  1  decoding instruction writes the register file.
- id_mem_read  input  1  decoding instruction is a load.
- flush  input  1  squash the instruction moving ID->EX (taken branch/jump).
- sel_a  output  2  forwarding select for ALU operand A.
- sel_b  output  2  forwarding select for ALU operand B.
- load_use_stall  output  1  hold PC and IF/ID; insert bubble into EX.

Behaviour:
- Select encoding, matching the mux: 2'b00 = register-file value, 2'b01 = EX/MEM ALU result, 2'b10 = MEM/WB write-back value. 2'b11 is never driven.
- Internal stages, each a flop set:
  - EX: valid, rs1, rs2, rd, reg_write, mem_read.
  - MEM: rd, reg_write.
  - WB: rd, reg_write.
- Per rising edge with arst_n=1:
  - WB <= MEM and MEM <= EX, unconditionally.
  - EX load priority: flush > load_use_stall > normal.
  - flush=1: EX <= bubble (valid=0, reg_write=0, mem_read=0, addresses 0).
  - load_use_stall=1 (no flush): EX <= bubble.
  - Otherwise: EX <= {id_valid, id_rs1, id_rs2, id_rd, id_reg_write & id_valid, id_mem_read & id_valid}.
- Reset: arst_n=0 at a rising edge clears every stage to bubble (all fields 0). Reset dominates flush and stall. Consequences:
  - Next cycle: sel_a = sel_b = 2'b00, load_use_stall = 0.
  - Any instruction in flight mid-reset is discarded and never forwards afterwards.
- sel_a is combinational from EX/MEM/WB flops only (no ID inputs); same cycle as the instruction occupying EX. Rules:
  - 2'b01 if MEM.reg_write and MEM.rd != ZERO_REG and MEM.rd == EX.rs1.
  - else 2'b10 if WB.reg_write and WB.rd != ZERO_REG and WB.rd == EX.rs1.
  - else 2'b00.
  - Forced to 2'b00 when EX.valid=0.
- sel_b: identical rules using EX.rs2.
- Priority: MEM over WB when both match (most recent producer wins).
- load_use_stall is combinational:
  - Asserted when EX.mem_read and EX.rd != ZERO_REG and id_valid and (id_rs1 == EX.rd or id_rs2 == EX.rd).
  - Forced to 0 while flush=1.
  - Asserts for exactly one cycle per load-use pair: the bubble clears EX.mem_read, and the load then reaches MEM, where sel = 2'b01 does not apply to load data because the consumer is still in ID. The consumer enters EX when the load is in WB and gets sel = 2'b10.
- No other sequential side effects; latency from ID inputs to sel outputs is exactly one clock.

Test Plan:
- Reset mid-stream: fill pipeline with writers to x5, assert arst_n=0 for one edge -> next cycle sel_a=sel_b=00, load_use_stall=0; following reader of x5 gets 00.
- EX/MEM forward: issue `add x3,..` then `sub x4,x3,x3` back-to-back -> when sub is in EX, sel_a=01, sel_b=01.
- MEM/WB forward and priority:
  - `add x3`, unrelated op, `or x6,x3,x1` -> or in EX gives sel_a=10, sel_b=00.
  - `add x3`, `addi x3`, `and x7,x3,x3` -> and in EX gives sel_a=sel_b=01, not 10.
- Zero register: `add x0,..` followed by `sub x4,x0,x0` -> sel_a=sel_b=00.
- Load-use: `lw x8,..` then `add x9,x8,x2` -> load_use_stall=1 for exactly one cycle; bubble in EX (sel 00); next cycle add in EX with sel_a=10, sel_b=00.
- Flush:
  - Writer to x5 enters with flush=1 -> following reader of x5 gets 00 in both later cycles.
  - flush=1 together with a load-use condition -> load_use_stall=0 and EX holds a bubble.

Source files
------------

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard control for the execute stage.
// Tracks EX/MEM/WB destination info and drives the ALU operand mux selects.
module fwd_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ZERO_REG   = 0
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            sel_a,
    output logic [1:0]            sel_b,
    output logic                  load_use_stall
);

    localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(ZERO_REG);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } ex_stage_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } wr_stage_t;

    ex_stage_t ex_q;
    ex_stage_t ex_d;
    wr_stage_t mem_q;
    wr_stage_t wb_q;

    // Most recent producer wins; the zero register is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic                  valid,
        input logic [REG_ADDR_W-1:0] rs,
        input wr_stage_t             mem,
        input wr_stage_t             wb
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (valid) begin
            if (mem.reg_write && (mem.rd != ZERO) && (mem.rd == rs)) begin
                sel = SEL_MEM;
            end else if (wb.reg_write && (wb.rd != ZERO) && (wb.rd == rs)) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        sel_a = fwd_sel(ex_q.valid, ex_q.rs1, mem_q, wb_q);
        sel_b = fwd_sel(ex_q.valid, ex_q.rs2, mem_q, wb_q);
    end

    // A load in EX whose result the decoding instruction needs cannot be forwarded in time.
    always_comb begin
        load_use_stall = 1'b0;
        if (!flush && ex_q.mem_read && (ex_q.rd != ZERO) && id_valid &&
            ((id_rs1 == ex_q.rd) || (id_rs2 == ex_q.rd))) begin
            load_use_stall = 1'b1;
        end
    end

    // Next EX contents: flush and stall both insert a bubble.
    always_comb begin
        ex_d = '0;
        if (!flush && !load_use_stall) begin
            ex_d.valid     = id_valid;
            ex_d.rs1       = id_rs1;
            ex_d.rs2       = id_rs2;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write & id_valid;
            ex_d.mem_read  = id_mem_read & id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q.rd        <= ex_q.rd;
            mem_q.reg_write <= ex_q.reg_write;
            wb_q          <= mem_q;
        end
    end

endmodule
